// File: rtl/shmem_cpl_tx_if.sv
// Shared types and the bundled handshake/stream interface for the completion drain stage.
package shmem_cpl_pkg;
  localparam int NUM_AVST_CH = 2;

  typedef struct packed {
    logic        valid;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } t_avst_pcie_rx;

  typedef t_avst_pcie_rx [NUM_AVST_CH-1:0] t_avst_pair;
endpackage

interface shmem_cpl_tx_if #(
  parameter int LOG2_TLP_BUF_SIZE = 7
);
  import shmem_cpl_pkg::*;

  logic                         send_req;
  logic                         send_ack;
  logic [LOG2_TLP_BUF_SIZE:0]   num_tx_packet;
  logic [LOG2_TLP_BUF_SIZE-1:0] tx_buf_idx;
  t_avst_pair                   tx_packet;
  t_avst_pair                   rx_st;
  logic                         rx_st_ready;

  // Drain stage side: pulls from the buffer, pushes the stream.
  modport master (
    input  send_req, num_tx_packet, tx_packet, rx_st_ready,
    output send_ack, tx_buf_idx, rx_st
  );

  // Buffer / sink side.
  modport slave (
    output send_req, num_tx_packet, tx_packet, rx_st_ready,
    input  send_ack, tx_buf_idx, rx_st
  );
endinterface

// File: rtl/shmem_cpl_tx.sv
// Drains buffered completion TLP entries two channels per beat onto the DUT RX
// AV-ST port, with ready backpressure, packet counting and a stall watchdog.
module shmem_cpl_tx
  import shmem_cpl_pkg::*;
#(
  parameter int TLP_BUF_SIZE      = 128,
  parameter int LOG2_TLP_BUF_SIZE = $clog2(TLP_BUF_SIZE),
  parameter int READY_TIMEOUT     = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  shmem_cpl_tx_if.master        bus,
  output logic [31:0]           pkt_cnt,
  output logic                  err_ready_timeout
);

  localparam int IW = LOG2_TLP_BUF_SIZE + 1;
  localparam int SW = $clog2(READY_TIMEOUT + 1);
  localparam int CW = $clog2(NUM_AVST_CH + 1);

  typedef enum logic [2:0] {IDLE, ACK, SEND, DRAIN, REL} state_t;

  state_t     state;
  logic       out_vld;
  logic       xfer;
  logic [CW-1:0] sop_add;
  logic [IW-1:0] idx_ext;
  logic       last_pair;
  t_avst_pair nxt_pair;
  logic [SW-1:0] stall_cnt;

  // Output stage status: any valid channel, transfer strobe, sop count of the beat.
  always_comb begin
    out_vld = 1'b0;
    sop_add = '0;
    for (int ch = 0; ch < NUM_AVST_CH; ch++) begin
      out_vld = out_vld | bus.rx_st[ch].valid;
      if (bus.rx_st[ch].valid && bus.rx_st[ch].sop) sop_add = sop_add + CW'(1);
    end
    xfer = out_vld & bus.rx_st_ready;
  end

  // Next pair to load: channels past the buffered count are zeroed so stale
  // buffer contents never leak onto the stream.
  always_comb begin
    idx_ext  = {1'b0, bus.tx_buf_idx};
    nxt_pair = '0;
    for (int ch = 0; ch < NUM_AVST_CH; ch++) begin
      if (idx_ext + IW'(ch) < bus.num_tx_packet) nxt_pair[ch] = bus.tx_packet[ch];
    end
    last_pair = (idx_ext + IW'(NUM_AVST_CH)) >= bus.num_tx_packet;
  end

  // Request/ack handshake, buffer index walk and the single output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.send_ack   <= 1'b0;
      bus.tx_buf_idx <= '0;
      bus.rx_st      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.send_req) begin
            bus.send_ack   <= 1'b1;
            bus.tx_buf_idx <= '0;
            state          <= ACK;
          end
        end
        ACK: begin
          if (!bus.send_req) state <= (bus.num_tx_packet == '0) ? REL : SEND;
        end
        SEND: begin
          // Refill whenever the register is empty or being drained this cycle,
          // giving one pair per clock under continuous ready.
          if (!out_vld || xfer) begin
            bus.rx_st <= nxt_pair;
            if (last_pair) state <= DRAIN;
            else bus.tx_buf_idx <= bus.tx_buf_idx + LOG2_TLP_BUF_SIZE'(NUM_AVST_CH);
          end
        end
        DRAIN: begin
          if (xfer) begin
            bus.rx_st <= '0;
            state     <= REL;
          end
        end
        REL: begin
          bus.send_ack   <= 1'b0;
          bus.tx_buf_idx <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Packet count and ready-stall watchdog; the error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt           <= '0;
      stall_cnt         <= '0;
      err_ready_timeout <= 1'b0;
    end else begin
      if (xfer) pkt_cnt <= pkt_cnt + 32'(sop_add);
      if (out_vld && !bus.rx_st_ready) begin
        if (stall_cnt != SW'(READY_TIMEOUT)) stall_cnt <= stall_cnt + SW'(1);
        if (stall_cnt == SW'(READY_TIMEOUT - 1)) err_ready_timeout <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule
